// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared definitions for the melody score sequencer: score word
//               field positions, end-of-song and rest encodings, sequencer
//               state encoding and tempo select codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    // Score word layout: {dur[15:12], code[11:0]}
    localparam int DUR_MSB  = 15;
    localparam int DUR_LSB  = 12;
    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 0;

    // A zero duration marks the end of the song; a zero code is a rest.
    localparam logic [3:0]  END_DUR   = 4'd0;
    localparam logic [11:0] REST_CODE = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;

    localparam logic [1:0] TEMPO_NORMAL     = 2'b00;
    localparam logic [1:0] TEMPO_FAST       = 2'b01;
    localparam logic [1:0] TEMPO_SLOW       = 2'b10;
    localparam logic [1:0] TEMPO_NORMAL_ALT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/score_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : score_sequencer_if
// Description : Bundle of playback commands, score RAM read bus and tone
//               outputs of the score sequencer.
//               master : sequencer side (drives RAM address and tone outputs)
//               slave  : environment side (commands, RAM data)
// Signals     : play/pause/stop pulses, loop_en, tempo_sel[1:0],
//               start_addr[ADDR_W], ram_re, ram_addr[ADDR_W], ram_data[16],
//               note_code[12], note_valid, busy, song_done
// Revision    : 1.0 - initial release
// ============================================================================
interface score_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              play;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [1:0]        tempo_sel;
    logic [ADDR_W-1:0] start_addr;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_data;
    logic [11:0]       note_code;
    logic              note_valid;
    logic              busy;
    logic              song_done;

    modport master (
        input  play, pause, stop, loop_en, tempo_sel, start_addr, ram_data,
        output ram_re, ram_addr, note_code, note_valid, busy, song_done
    );

    modport slave (
        output play, pause, stop, loop_en, tempo_sel, start_addr, ram_data,
        input  ram_re, ram_addr, note_code, note_valid, busy, song_done
    );
endinterface
`default_nettype wire

// File: rtl/tempo_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tempo_tick_gen
// Description : Down-counting tempo tick generator. Counts from period-1 to 0
//               and fires tick on the zero cycle, then reloads. The period is
//               chosen by tempo_sel at every reload, so a tempo change never
//               cuts the running period short.
// Ports       : sys_clk, rst_n (async, active low)
//               en        - advance the counter this cycle
//               clr       - reload with the current period (start of a note)
//               tempo_sel - 00/11 normal, 01 half period, 10 double period
//               tick      - one-cycle pulse when the counter wraps
//               tick_cnt  - current count, used for the articulation gap
// Revision    : 1.0 - initial release
// ============================================================================
module tempo_tick_gen
    import score_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = $clog2(2 * TICK_DIV)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       tempo_sel,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam logic [CNT_W-1:0] c_load_normal = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_load_fast   = CNT_W'(TICK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_load_slow   = CNT_W'(2 * TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;

    always_comb begin
        w_load = c_load_normal;
        case (tempo_sel)
            TEMPO_FAST: w_load = c_load_fast;
            TEMPO_SLOW: w_load = c_load_slow;
            default:    w_load = c_load_normal;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= w_load;
        end else if (en) begin
            if (r_cnt == '0) begin
                r_cnt <= w_load;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign tick     = en && (r_cnt == '0);
    assign tick_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : score_sequencer
// Description : Command-driven melody playback controller. Fetches note words
//               from the score RAM, holds each note for dur tempo ticks with a
//               short muted gap at the end, and supports play / pause / stop,
//               looping and three tempos.
// Ports       : sys_clk     - system clock
//               rst_n       - asynchronous active-low reset
//               bus.master  - commands, score RAM read bus, tone outputs
// Revision    : 1.0 - initial release
// ============================================================================
module score_sequencer
    import score_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 4,
    parameter int TICK_DIV = CLK_HZ / TICK_HZ,
    parameter int ADDR_W   = 8,
    parameter int GAP_CYC  = 1250000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    score_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(2 * TICK_DIV);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [11:0]       r_note_code;
    logic [3:0]        r_remaining;

    logic              w_tick;
    logic              w_tick_en;
    logic              w_tick_clr;
    logic [CNT_W-1:0]  w_tick_cnt;
    logic [3:0]        w_dur;
    logic [11:0]       w_code;
    logic              w_last_tick;

    assign w_dur  = bus.ram_data[DUR_MSB:DUR_LSB];
    assign w_code = bus.ram_data[CODE_MSB:CODE_LSB];

    // A cycle carrying a pause or stop command does not advance the note,
    // so a resumed note plays exactly its remaining cycles.
    assign w_tick_en   = (r_state == ST_PLAY) && !bus.stop && !bus.pause;
    assign w_tick_clr  = (r_state == ST_DECODE);
    assign w_last_tick = w_tick && (r_remaining == 4'd1);

    tempo_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tempo_tick_gen (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .en        (w_tick_en),
        .clr       (w_tick_clr),
        .tempo_sel (bus.tempo_sel),
        .tick      (w_tick),
        .tick_cnt  (w_tick_cnt)
    );

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; command priority is stop > pause > play
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.play) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_nxt = bus.stop ? ST_IDLE : ST_DECODE;
            end
            ST_DECODE: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dur == END_DUR) begin
                    w_state_nxt = bus.loop_en ? ST_FETCH : ST_IDLE;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.pause) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_last_tick) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_PAUSED: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.pause || bus.play) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address, note and duration registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_note_code <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.play) r_ram_addr <= bus.start_addr;
                end
                ST_DECODE: begin
                    if (!bus.stop) begin
                        if (w_dur == END_DUR) begin
                            if (bus.loop_en) r_ram_addr <= bus.start_addr;
                        end else begin
                            r_note_code <= w_code;
                            r_remaining <= w_dur;
                        end
                    end
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        r_remaining <= r_remaining - 4'd1;
                        // Address wraps naturally at 2^ADDR_W
                        if (w_last_tick) r_ram_addr <= r_ram_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.ram_re     = (r_state == ST_FETCH);
        bus.ram_addr   = r_ram_addr;
        bus.note_code  = r_note_code;
        bus.busy       = (r_state != ST_IDLE);
        bus.song_done  = (r_state == ST_DECODE) && (w_dur == END_DUR);
        // Mute during the last GAP_CYC cycles of the final tick so that
        // repeated notes are heard as separate notes.
        bus.note_valid = (r_state == ST_PLAY) && (r_note_code != REST_CODE) &&
                         !((r_remaining == 4'd1) && (w_tick_cnt < CNT_W'(GAP_CYC)));
    end

endmodule
`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_sequencer
// Description : Self-checking bench for score_sequencer. Songs from a vector
//               table are scored segment by segment (one segment per RAM
//               fetch) against a queue of expected segments; pause, loop,
//               command priority and reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_sequencer;

    localparam int TICK_DIV = 8;
    localparam int GAP_CYC  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_sequencer_if #(.ADDR_W(8)) bus ();

    score_sequencer #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (8),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Score RAM with one cycle read latency
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_data <= mem[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [11:0] code;
        int          valid;
        int          len;
        int          done;
    } seg_t;

    seg_t        sb_q [$];
    logic [11:0] exp_code = 12'h000;

    // Expected segments for one pass of the song starting at start
    task automatic model_song(input logic [7:0] start, input logic [1:0] tempo);
        int          p;
        logic [7:0]  a;
        logic [15:0] w;
        seg_t        e;
        bit          fin;
        p   = (tempo == 2'b01) ? TICK_DIV / 2 : (tempo == 2'b10) ? 2 * TICK_DIV : TICK_DIV;
        a   = start;
        fin = 1'b0;
        for (int k = 0; k < 16 && !fin; k++) begin
            w      = mem[a];
            e.addr = a;
            if (w[15:12] == 4'd0) begin
                e.code  = exp_code;
                e.valid = 0;
                e.len   = 2;
                e.done  = 1;
                fin     = 1'b1;
            end else begin
                e.code   = w[11:0];
                e.len    = 2 + int'(w[15:12]) * p;
                e.valid  = (w[11:0] == 12'h000) ? 0 : int'(w[15:12]) * p - GAP_CYC;
                e.done   = 0;
                exp_code = w[11:0];
                a        = a + 8'd1;
            end
            sb_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    bit          mon_en   = 1'b0;
    bit          seg_open = 1'b0;
    logic [7:0]  seg_addr;
    logic [11:0] seg_code;
    int          seg_len, seg_valid, seg_done;

    task automatic close_seg();
        seg_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_seg: got segment at addr %0h expected none", seg_addr);
        end else begin
            e = sb_q.pop_front();
            chk("seg_addr",  32'(seg_addr),  32'(e.addr));
            chk("seg_code",  32'(seg_code),  32'(e.code));
            chk("seg_valid", 32'(seg_valid), 32'(e.valid));
            chk("seg_len",   32'(seg_len),   32'(e.len));
            chk("seg_done",  32'(seg_done),  32'(e.done));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.ram_re) begin
                    if (seg_open) close_seg();
                    seg_open  = 1'b1;
                    seg_addr  = bus.ram_addr;
                    seg_len   = 0;
                    seg_valid = 0;
                    seg_done  = 0;
                end else if (seg_open && !bus.busy) begin
                    close_seg();
                    seg_open = 1'b0;
                end
                if (seg_open) begin
                    seg_len++;
                    seg_valid += int'(bus.note_valid);
                    seg_done  += int'(bus.song_done);
                    seg_code   = bus.note_code;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic load3(input logic [7:0] start, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2);
        logic [7:0] a;
        a = start;      mem[a] = w0;
        a = a + 8'd1;   mem[a] = w1;
        a = a + 8'd1;   mem[a] = w2;
    endtask

    // Returns at the negedge of the cycle after play was sampled (FETCH)
    task automatic pulse_play();
        @(negedge clk) bus.play = 1'b1;
        @(negedge clk) bus.play = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.note_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(name, 32'(bus.note_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2;
        logic [7:0]  start;
        logic [1:0]  tempo;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, d, v, r;

        bus.play = 0; bus.pause = 0; bus.stop = 0; bus.loop_en = 0;
        bus.tempo_sel = 2'b00; bus.start_addr = 8'h00; bus.ram_data = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        vecs[0] = '{16'h4003, 16'h1005, 16'h0000, 8'h00, 2'b00, 46, 1};
        vecs[1] = '{16'h2000, 16'h1007, 16'h0000, 8'h10, 2'b00, 30, 1};
        vecs[2] = '{16'h1abc, 16'h2001, 16'h0000, 8'h20, 2'b01, 18, 1};
        vecs[3] = '{16'h1abc, 16'h2001, 16'h0000, 8'h30, 2'b10, 54, 1};
        vecs[4] = '{16'h1003, 16'h0000, 16'h0000, 8'hff, 2'b00, 12, 1};
        vecs[5] = '{16'h3fff, 16'h1100, 16'h0000, 8'h80, 2'b11, 38, 1};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ram_re",     32'(bus.ram_re),     32'd0);
        chk("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
        chk("rst_note_code",  32'(bus.note_code),  32'd0);
        chk("rst_note_valid", 32'(bus.note_valid), 32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_song_done",  32'(bus.song_done),  32'd0);
        rst_n = 1'b1;
        r = 0;
        repeat (20) begin
            @(negedge clk);
            r += int'(bus.ram_re) + int'(bus.busy);
        end
        chk("idle_no_activity", 32'(r), 32'd0);

        // ---- table-driven songs ----
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load3(vecs[i].start, vecs[i].w0, vecs[i].w1, vecs[i].w2);
            bus.tempo_sel  = vecs[i].tempo;
            bus.start_addr = vecs[i].start;
            model_song(vecs[i].start, vecs[i].tempo);
            pulse_play();
            chk("ram_re_n_plus_1", 32'(bus.ram_re), 32'd1);
            n = 0;
            d = 0;
            while (bus.busy && n < 1000) begin
                n++;
                d += int'(bus.song_done);
                @(negedge clk);
            end
            chk("song_busy_cycles", 32'(n), 32'(vecs[i].exp_busy));
            chk("song_done_count",  32'(d), 32'(vecs[i].exp_done));
            repeat (2) @(negedge clk);
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
        end
        mon_en = 1'b0;
        bus.tempo_sel = 2'b00;

        // ---- latency and pause/resume ----
        load3(8'h00, 16'h4003, 16'h1005, 16'h0000);
        bus.start_addr = 8'h00;
        pulse_play();
        chk("lat_ram_re_n1", 32'(bus.ram_re), 32'd1);
        @(negedge clk);
        chk("lat_valid_n2", 32'(bus.note_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_n3", 32'(bus.note_valid), 32'd1);
        chk("lat_code_n3",  32'(bus.note_code),  32'h003);
        repeat (16) @(negedge clk);
        bus.pause = 1'b1;
        @(negedge clk) bus.pause = 1'b0;
        chk("paused_valid", 32'(bus.note_valid), 32'd0);
        chk("paused_busy",  32'(bus.busy),       32'd1);
        v = 0;
        r = 0;
        repeat (20) begin
            @(negedge clk);
            v += int'(bus.note_valid);
            r += int'(bus.ram_re);
        end
        chk("paused_hold_valid", 32'(v), 32'd0);
        chk("paused_hold_ram_re", 32'(r), 32'd0);
        bus.pause = 1'b1;
        @(negedge clk) bus.pause = 1'b0;
        n = 0;
        v = 0;
        while (!bus.ram_re && bus.busy && n < 200) begin
            n++;
            v += int'(bus.note_valid);
            @(negedge clk);
        end
        chk("resume_play_cycles", 32'(n), 32'd16);
        chk("resume_valid_cycles", 32'(v), 32'd14);
        chk("resume_next_addr", 32'(bus.ram_addr), 32'd1);
        wait_idle("pause_song_idle");

        // ---- loop mode ----
        exp_code    = 12'h005;
        bus.loop_en = 1'b1;
        model_song(8'h00, 2'b00);
        model_song(8'h00, 2'b00);
        mon_en = 1'b1;
        pulse_play();
        r = int'(bus.ram_re);
        n = 0;
        while (r < 7 && n < 500) begin
            @(negedge clk);
            n++;
            r += int'(bus.ram_re);
        end
        chk("loop_fetch_count", 32'(r), 32'd7);
        repeat (3) @(negedge clk);
        mon_en   = 1'b0;
        seg_open = 1'b0;
        chk("loop_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("loop_replay_code", 32'(bus.note_code), 32'h003);
        bus.stop = 1'b1;
        @(negedge clk) bus.stop = 1'b0;
        chk("loop_stop_busy",  32'(bus.busy),       32'd0);
        chk("loop_stop_valid", 32'(bus.note_valid), 32'd0);
        chk("loop_stop_addr",  32'(bus.ram_addr),   32'd0);
        bus.loop_en = 1'b0;

        // ---- simultaneous commands ----
        pulse_play();
        wait_valid("cmd_wait_play");
        bus.stop = 1'b1; bus.pause = 1'b1; bus.play = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.pause = 1'b0; bus.play = 1'b0;
        chk("cmd_all_busy",  32'(bus.busy),       32'd0);
        chk("cmd_all_valid", 32'(bus.note_valid), 32'd0);
        @(negedge clk);
        chk("cmd_all_stays_idle", 32'(bus.busy), 32'd0);

        // ---- asynchronous reset mid-note ----
        load3(8'h40, 16'h4003, 16'h0000, 16'h0000);
        bus.start_addr = 8'h40;
        pulse_play();
        wait_valid("rst_wait_play");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",     32'(bus.note_valid), 32'd0);
        chk("arst_busy",      32'(bus.busy),       32'd0);
        chk("arst_ram_addr",  32'(bus.ram_addr),   32'd0);
        chk("arst_note_code", 32'(bus.note_code),  32'd0);
        @(negedge clk) rst_n = 1'b1;
        r = 0;
        repeat (10) begin
            @(negedge clk);
            r += int'(bus.busy) + int'(bus.ram_re);
        end
        chk("arst_no_restart", 32'(r), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
Playback controller for the melody datapath. It steps through note records in the score RAM and generates the tempo tick. It drives the 12-bit note code and a tone-enable to the frequency ROM / tone divider. It accepts play/pause/stop commands and a loop mode, and signals end-of-song. This replaces a free-running 4 Hz counter with a command-driven sequencer.

Parameters:
CLK_HZ, 100000000, sys_clk frequency
TICK_HZ, 4, nominal tempo ticks per second; TICK_DIV = CLK_HZ/TICK_HZ (bench overrides TICK_DIV directly)
ADDR_W, 8, score RAM address width
GAP_CYC, 1250000, articulation gap: tone muted for the last GAP_CYC cycles of each note; must be < TICK_DIV/2

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
play  in  1  single-cycle pulse: start from IDLE / resume from PAUSED
pause  in  1  single-cycle pulse: toggle PLAY<->PAUSED
stop  in  1  single-cycle pulse: abort to IDLE
loop_en  in  1  level: restart at start_addr on end marker
tempo_sel  in  2  00 normal, 01 fast (tick period TICK_DIV/2), 10 slow (2*TICK_DIV), 11 normal
start_addr  in  ADDR_W  first score address, sampled on play from IDLE
ram_re  out  1  score RAM read enable
ram_addr  out  ADDR_W  score RAM address
ram_data  in  16  score word {dur[15:12], code[11:0]}, valid the cycle after ram_re
note_code  out  12  {high,med,low} nibbles to frequency ROM / seven-seg
note_valid  out  1  tone enable
busy  out  1  high in any state except IDLE
song_done  out  1  one-cycle pulse on end marker

Behaviour:
- Reset (async, rst_n=0): state IDLE; ram_re=0, ram_addr=0, note_code=0, note_valid=0, busy=0, song_done=0; tick and duration counters cleared.
- States: IDLE, FETCH, DECODE, PLAY, PAUSED. Registered state; ram_re=1 only in FETCH.
- IDLE: on play, latch ram_addr<=start_addr and go to FETCH. pause and stop are ignored.
- FETCH: ram_re=1 for exactly one cycle, then DECODE.
- DECODE: samples ram_data.
  - If dur==0 (end marker): pulse song_done.
    - loop_en=1: ram_addr<=start_addr, go to FETCH.
    - loop_en=0: go to IDLE, note_valid=0.
  - If dur!=0: note_code<=code, remaining<=dur, reload tick counter, go to PLAY.
- Latency: play in cycle n -> ram_re=1 in n+1 -> data sampled n+2 -> note_valid valid from n+3.
- PLAY:
  - Tick counter counts down from period-1 and wraps to 0 each tick.
  - On each tick, remaining decrements.
  - When the tick with remaining==1 occurs: ram_addr<=ram_addr+1 (mod 2^ADDR_W, 0xFF wraps to 0x00), go to FETCH.
- note_valid = (state==PLAY) && (note_code!=0) && !(remaining==1 && tick_cnt<GAP_CYC).
  - Code 000 is a rest: silent for its full duration.
  - note_valid is 0 in FETCH/DECODE; note_code holds its previous value there.
- Note timing: each note of dur d occupies d*period cycles in PLAY, plus 2 cycles FETCH/DECODE overhead.
- PAUSED: entered from PLAY on pause. Tick and remaining counters are frozen; note_valid=0; note_code is held. pause or play returns to PLAY and resumes at the exact frozen count.
- stop: from any non-IDLE state, go to IDLE next cycle; note_valid=0; ram_addr is held.
- Simultaneous commands: stop > pause > play.
- tempo_sel change takes effect at the next tick-counter reload. The current tick period completes first.
- FETCH/DECODE ignore pause, which acts only in PLAY. stop is honoured in FETCH/DECODE.
- loop_en is sampled only in DECODE.
- rst_n asserted mid-operation forces all outputs to their reset values immediately (async). Operation restarts only on a new play.

Decomposition:
- Package score_pkg: score word field positions (DUR_MSB/LSB, CODE_MSB/LSB), END_DUR=0, REST_CODE=12'h000, state enum, tempo_sel encodings.
- Sub-module tempo_tick_gen:
  - Inputs: sys_clk, rst_n, en, clr, tempo_sel.
  - Outputs: tick pulse, tick_cnt.
  - Period: TICK_DIV, >>1 or <<1 per tempo_sel; counter width $clog2(2*TICK_DIV).
- Sequencer FSM lives in score_sequencer.

Test Plan:
(Bench uses TICK_DIV=8, GAP_CYC=2, 1-cycle-latency RAM model.)
1. Reset: rst_n=0 -> all outputs 0. Release with no play -> state stays IDLE, ram_re never asserted.
2. Basic playback: score [0]=0x4003, [1]=0x1005, [2]=0x0000; play with start_addr=0.
   - ram_re at n+1; note_code=003 from n+3.
   - note_valid high 30 cycles, low 2 (gap); then 2-cycle fetch.
   - note_code=005, valid 6 cycles.
   - song_done pulses once; busy=0.
3. Loop: same score, loop_en=1 -> after [2], ram_addr returns to 0 and 003 replays. song_done pulses once per pass. stop -> IDLE within 1 cycle.
4. Pause/resume: pause at tick 2 of note 003, hold 20 cycles -> note_valid=0 and counters frozen. pause again -> exactly 16 remaining PLAY cycles before FETCH of [1].
5. Commands and tempo:
   - stop+pause+play in the same PLAY cycle -> IDLE.
   - Word 0x2000 -> note_valid=0 for 16 cycles.
   - tempo_sel=01 -> tick every 4 cycles; 10 -> every 16.
6. Wrap and reset: start_addr=0xFF with word 0x1003 -> next ram_addr=0x00. rst_n pulse mid-PLAY -> note_valid, busy, ram_addr 0 immediately.
